// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
//   - Access size encodings (byte / half / word / illegal).
//   - FSM state enumeration for mem_access_stage.
//   - is_misaligned(): true when a request cannot be performed as issued.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;  // reserved / illegal encoding

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  // Half-words need addr[0]==0, words need addr[1:0]==0, size 3 is never legal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering between a 32-bit memory word and sub-word accesses.
//   word_i    : word read from memory
//   lane_i    : byte offset within the word (addr[1:0], already naturally aligned)
//   size_i    : access size (SZ_B / SZ_H / SZ_W)
//   uns_i     : zero-extend loads when 1
//   wdata_i   : store data, sub-word data taken from the low bytes
//   load_o    : extracted and extended load result
//   merged_o  : word_i with the addressed lane(s) replaced by store data
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{lane_i, 3'b000} +: 8];
    half_v = word_i[{lane_i[1], 4'b0000} +: 16];
    case (size_i)
      SZ_B:    load_o = uns_i ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_H:    load_o = uns_i ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_o = word_i;  // word loads ignore uns_i
    endcase
  end

  // Each byte lane independently decides whether it is overwritten and,
  // if so, which byte of the store data lands there.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       hit;
      logic [7:0] src;
      always_comb begin
        case (size_i)
          SZ_B: begin
            hit = (lane_i == LANE);
            src = wdata_i[7:0];
          end
          SZ_H: begin
            hit = (lane_i[1] == LANE[1]);
            src = wdata_i[8*(gi%2) +: 8];
          end
          default: begin
            hit = 1'b1;
            src = wdata_i[8*gi +: 8];
          end
        endcase
      end
      assign merged_o[8*gi +: 8] = hit ? src : word_i[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory-access stage in front of a word-addressed memory unit.
// Accepts one load/store at a time, checks alignment, performs sub-word
// extraction on loads and read-modify-write on sub-word stores, and returns
// a tagged response.
//   _clk, _reset                 : clock, synchronous active-high reset
//   _req_* / req_ready_          : request channel from execute
//   resp_* / _resp_ready         : response channel to writeback
//   mem_we_, mem_data_, mem_vptr_: memory unit write enable, data, word pointer
//   _mem_value                   : memory read data, valid after the pointer
//                                  has been stable for one full cycle
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int TAG_W           = 5,
  parameter int TRAP_MISALIGNED = 1
) (
  input  logic             _clk,
  input  logic             _reset,
  input  logic             _req_valid,
  output logic             req_ready_,
  input  logic             _req_we,
  input  logic [1:0]       _req_size,
  input  logic             _req_unsigned,
  input  logic [31:0]      _req_addr,
  input  logic [31:0]      _req_wdata,
  input  logic [TAG_W-1:0] _req_tag,
  output logic             resp_valid_,
  input  logic             _resp_ready,
  output logic [31:0]      resp_data_,
  output logic [TAG_W-1:0] resp_tag_,
  output logic             resp_err_,
  output logic             mem_we_,
  output logic [31:0]      mem_data_,
  output logic [31:0]      mem_vptr_,
  input  logic [31:0]      _mem_value
);

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       lane_q, lane_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      vptr_q, vptr_d;
  logic [31:0]      mem_data_q, mem_data_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;

  logic [1:0]  eff_size;
  logic [1:0]  eff_lane;
  logic        misaligned;
  logic [31:0] load_result;
  logic [31:0] merged_word;

  // When not trapping, size 3 is treated as a word and the low address bits
  // are cleared down to natural alignment.
  always_comb begin
    eff_size   = (_req_size == SZ_X) ? SZ_W : _req_size;
    misaligned = is_misaligned(_req_size, _req_addr[1:0]);
    case (eff_size)
      SZ_H:    eff_lane = {_req_addr[1], 1'b0};
      SZ_W:    eff_lane = 2'b00;
      default: eff_lane = _req_addr[1:0];
    endcase
  end

  mem_lane_align u_align (
    .word_i   (_mem_value),
    .lane_i   (lane_q),
    .size_i   (size_q),
    .uns_i    (uns_q),
    .wdata_i  (wdata_q),
    .load_o   (load_result),
    .merged_o (merged_word)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    tag_d       = tag_q;
    vptr_d      = vptr_q;
    mem_data_d  = mem_data_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (_req_valid) begin
          we_d        = _req_we;
          size_d      = eff_size;
          uns_d       = _req_unsigned;
          lane_d      = eff_lane;
          wdata_d     = _req_wdata;
          tag_d       = _req_tag;
          resp_data_d = 32'd0;
          resp_err_d  = 1'b0;
          if ((TRAP_MISALIGNED != 0) && misaligned) begin
            // Error response goes straight out; the memory port is untouched.
            resp_err_d = 1'b1;
            state_d    = ST_RESP;
          end else begin
            vptr_d = {_req_addr[31:2], 2'b00};
            if (_req_we && (eff_size == SZ_W)) begin
              mem_data_d = _req_wdata;
              state_d    = ST_WR;
            end else begin
              state_d = ST_RD0;
            end
          end
        end
      end
      ST_RD0: state_d = ST_RD1;
      ST_RD1: begin
        // Pointer has now been stable for two cycles: _mem_value is valid.
        if (we_q) begin
          mem_data_d = merged_word;
          state_d    = ST_WR;
        end else begin
          resp_data_d = load_result;
          state_d     = ST_RESP;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: if (_resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge _clk) begin
    if (_reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 32'd0;
      tag_q       <= '0;
      vptr_q      <= 32'd0;
      mem_data_q  <= 32'd0;
      resp_data_q <= 32'd0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      tag_q       <= tag_d;
      vptr_q      <= vptr_d;
      mem_data_q  <= mem_data_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign req_ready_  = (state_q == ST_IDLE);
  assign resp_valid_ = (state_q == ST_RESP);
  assign resp_data_  = resp_data_q;
  assign resp_tag_   = tag_q;
  assign resp_err_   = resp_err_q;
  // Gated by reset so an aborted store never commits, even in the reset cycle.
  assign mem_we_     = (state_q == ST_WR) && !_reset;
  assign mem_data_   = mem_data_q;
  assign mem_vptr_   = vptr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_tag = 5'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_data;
  logic [31:0] mem_vptr;
  logic [31:0] mem_value;

  // memory model
  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_data = 32'd0;
  int          we_cnt = 0;
  logic [31:0] last_vptr = 32'd0;
  logic [31:0] last_data = 32'd0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TAG_W(5), .TRAP_MISALIGNED(1)) dut (
    ._clk          (clk),
    ._reset        (rst),
    ._req_valid    (req_valid),
    .req_ready_    (req_ready),
    ._req_we       (req_we),
    ._req_size     (req_size),
    ._req_unsigned (req_uns),
    ._req_addr     (req_addr),
    ._req_wdata    (req_wdata),
    ._req_tag      (req_tag),
    .resp_valid_   (resp_valid),
    ._resp_ready   (resp_ready),
    .resp_data_    (resp_data),
    .resp_tag_     (resp_tag),
    .resp_err_     (resp_err),
    .mem_we_       (mem_we),
    .mem_data_     (mem_data),
    .mem_vptr_     (mem_vptr),
    ._mem_value    (mem_value)
  );

  // Read data is registered: valid one cycle after the pointer settles.
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_we) mem[mem_vptr[7:2]] <= mem_data;
    mem_value <= mem[mem_vptr[7:2]];
    if (mem_we) begin
      we_cnt    <= we_cnt + 1;
      last_vptr <= mem_vptr;
      last_data <= mem_data;
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] d);
    pre_we = 1'b1; pre_idx = idx; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tg);
    req_we = we; req_size = sz; req_uns = uns; req_addr = a; req_wdata = wd; req_tag = tg;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 0;
    while (!resp_valid && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake(input string name);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check({name, ".released"}, {31'd0, resp_valid}, 32'd0);
    check({name, ".ready_again"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic xact(input string name, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] tg,
                      input int lat, input logic [31:0] exp_data, input logic exp_err,
                      input int exp_writes);
    int cyc;
    int w0;
    w0 = we_cnt;
    check({name, ".accept_ready"}, {31'd0, req_ready}, 32'd1);
    issue(we, sz, uns, a, wd, tg);
    wait_resp(cyc);
    check({name, ".latency"}, cyc, lat);
    check({name, ".data"}, resp_data, exp_data);
    check({name, ".tag"}, {27'd0, resp_tag}, {27'd0, tg});
    check({name, ".err"}, {31'd0, resp_err}, {31'd0, exp_err});
    handshake(name);
    check({name, ".writes"}, we_cnt - w0, exp_writes);
    $display("xact %s we=%0d size=%0d addr=%h wdata=%h tag=%0d -> data=%h err=%0d lat=%0d",
             name, we, sz, a, wd, tg, resp_data, resp_err, cyc);
  endtask

  initial begin
    int cyc;
    int w0;

    // reset, with memory preloaded meanwhile
    preload(6'd16, 32'h80F1_7F22);  // 0x40
    preload(6'd18, 32'h1122_3344);  // 0x48
    check("rst.req_ready", {31'd0, req_ready}, 32'd1);
    check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst.mem_we", {31'd0, mem_we}, 32'd0);
    check("rst.resp_data", resp_data, 32'd0);
    check("rst.resp_err", {31'd0, resp_err}, 32'd0);
    check("rst.resp_tag", {27'd0, resp_tag}, 32'd0);
    check("rst.mem_vptr", mem_vptr, 32'd0);
    check("rst.mem_data", mem_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // loads with extraction / extension
    xact("lb42",  1'b0, 2'd0, 1'b0, 32'h42, 32'h0, 5'd1, 2, 32'hFFFF_FFF1, 1'b0, 0);
    xact("lbu42", 1'b0, 2'd0, 1'b1, 32'h42, 32'h0, 5'd2, 2, 32'h0000_00F1, 1'b0, 0);
    xact("lb41",  1'b0, 2'd0, 1'b0, 32'h41, 32'h0, 5'd3, 2, 32'h0000_007F, 1'b0, 0);
    xact("lh42",  1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 5'd4, 2, 32'hFFFF_80F1, 1'b0, 0);

    // word store then read-back
    xact("sw44", 1'b1, 2'd2, 1'b0, 32'h44, 32'hDEAD_BEEF, 5'd5, 1, 32'h0, 1'b0, 1);
    check("sw44.vptr", last_vptr, 32'h44);
    check("sw44.wdata", last_data, 32'hDEAD_BEEF);
    xact("lw44", 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 5'd6, 2, 32'hDEAD_BEEF, 1'b0, 0);

    // sub-word stores (read-modify-write)
    xact("sb4a", 1'b1, 2'd0, 1'b0, 32'h4A, 32'h1234_56AA, 5'd7, 3, 32'h0, 1'b0, 1);
    check("sb4a.vptr", last_vptr, 32'h48);
    check("sb4a.word", last_data, 32'h11AA_3344);
    xact("sh48", 1'b1, 2'd1, 1'b0, 32'h48, 32'hFFFF_BBCC, 5'd8, 3, 32'h0, 1'b0, 1);
    check("sh48.word", last_data, 32'h11AA_BBCC);
    xact("lw48", 1'b0, 2'd2, 1'b0, 32'h48, 32'h0, 5'd9, 2, 32'h11AA_BBCC, 1'b0, 0);

    // misaligned / illegal
    xact("lw43", 1'b0, 2'd2, 1'b0, 32'h43, 32'h0, 5'd10, 0, 32'h0, 1'b1, 0);
    xact("sh45", 1'b1, 2'd1, 1'b0, 32'h45, 32'h5555_5555, 5'd11, 0, 32'h0, 1'b1, 0);
    xact("sz3",  1'b1, 2'd3, 1'b0, 32'h40, 32'h6666_6666, 5'd12, 0, 32'h0, 1'b1, 0);
    check("illegal.mem40", mem[16], 32'h80F1_7F22);
    check("illegal.mem44", mem[17], 32'hDEAD_BEEF);
    xact("lw40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5'd13, 2, 32'h80F1_7F22, 1'b0, 0);

    // back-pressure on the response
    issue(1'b0, 2'd1, 1'b1, 32'h40, 32'h0, 5'd7);
    wait_resp(cyc);
    check("bp.latency", cyc, 2);
    req_we = 1'b0; req_size = 2'd0; req_uns = 1'b1; req_addr = 32'h40; req_tag = 5'd9;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.hold_valid", {31'd0, resp_valid}, 32'd1);
      check("bp.hold_data", resp_data, 32'h0000_7F22);
      check("bp.hold_tag", {27'd0, resp_tag}, 32'd7);
      check("bp.hold_ready", {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp.after_hs_valid", {31'd0, resp_valid}, 32'd0);
    check("bp.after_hs_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp.accepted", {31'd0, req_ready}, 32'd0);
    wait_resp(cyc);
    check("bp.next_latency", cyc, 2);
    check("bp.next_data", resp_data, 32'h0000_0022);
    check("bp.next_tag", {27'd0, resp_tag}, 32'd9);
    handshake("bp.next");
    $display("xact bp lhu40 tag=7 held 5 cycles, then lbu40 tag=9 data=%h", 32'h22);

    // reset during the write cycle of a sub-word store
    issue(1'b1, 2'd0, 1'b0, 32'h40, 32'h0000_0055, 5'd14);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstwr.in_wr", {31'd0, mem_we}, 32'd1);
    w0 = we_cnt;
    rst = 1'b1;
    #1;
    check("rstwr.we_gated", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstwr.req_ready", {31'd0, req_ready}, 32'd1);
    check("rstwr.resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rstwr.mem_data", mem_data, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rstwr.no_resp", {31'd0, resp_valid}, 32'd0);
    end
    check("rstwr.writes", we_cnt - w0, 0);
    check("rstwr.mem40", mem[16], 32'h80F1_7F22);
    $display("xact sb40 aborted by reset in WR, writes=%0d", we_cnt - w0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
